div_12: RTL and testbench

DIV_12 -- requirements
Module: div_12

---
 rtl/div_12_pkg.sv | 32 +++
 rtl/div_core_7.sv | 76 +++++++
 rtl/div_12.sv | 130 +++++++++++++
 tb/tb_div_12.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/div_12_pkg.sv
// div_12_pkg: shared constants and FSM encoding for the 12-bit float divider.
// Word format: sign[11], exponent[10:6] (bias 15), mantissa[5:0] with a
// hidden leading 1.
package div_12_pkg;

  localparam int WORD_W   = 12;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 6;
  localparam int SIG_W    = MANT_W + 1;   // mantissa with hidden 1
  localparam int QUOT_W   = 8;            // q[7] integer, q[6:0] fraction
  localparam int REM_W    = 8;
  localparam int CNT_W    = 3;
  localparam int EXPT_W   = 7;            // signed intermediate exponent

  localparam logic signed [EXPT_W-1:0] BIAS    = 7'sd15;
  localparam logic signed [EXPT_W-1:0] EXP_MAX = 7'sd31;
  localparam logic [MANT_W-1:0]        SAT_MANT = 6'd63;
  localparam logic [WORD_W-1:0]        ZERO_WORD = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_PACK   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Saturated (infinity-like) word carrying the result sign.
  function automatic logic [WORD_W-1:0] sat_word(input logic sign);
    return {sign, EXP_MAX[EXP_W-1:0], SAT_MANT};
  endfunction

endpackage

// File: rtl/div_core_7.sv
// div_core_7: restoring divider for 7-bit significands, one step per cycle.
// Ports:
//   clk_i, rst_n_i  clock / async active-low reset
//   start_i         load dividend/divisor, clear quotient and step counter
//   dividend_i      {1, m1}
//   divisor_i       {1, m2}
//   done_o          high during the last step (counter == 7); the quotient
//                   is complete after the edge on which done_o is high
//   quot_o          8-bit quotient, q[7] integer bit
module div_core_7
  import div_12_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [SIG_W-1:0]  dividend_i,
  input  logic [SIG_W-1:0]  divisor_i,
  output logic              done_o,
  output logic [QUOT_W-1:0] quot_o
);

  logic [REM_W-1:0]  rem_q,  rem_d;
  logic [SIG_W-1:0]  dvs_q,  dvs_d;
  logic [QUOT_W-1:0] quot_q, quot_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              busy_q, busy_d;

  logic              ge;
  logic [REM_W-1:0]  diff;

  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    ge     = (rem_q >= {1'b0, dvs_q});
    diff   = ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
    if (start_i) begin
      rem_d  = {1'b0, dividend_i};
      dvs_d  = divisor_i;
      quot_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // diff < divisor < 128, so the shift never drops a set bit.
      rem_d  = {diff[REM_W-2:0], 1'b0};
      quot_d = {quot_q[QUOT_W-2:0], ge};
      if (cnt_q == 3'd7) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == 3'd7);
  assign quot_o = quot_q;

endmodule

// File: rtl/div_12.sv
// div_12: iterative divider for a 12-bit float format
// (sign[11], exp[10:6] bias 15, mantissa[5:0] hidden 1).
// Ports:
//   clk_i, rst_n_i      clock / async active-low reset
//   data_1_i, data_2_i  dividend / divisor, captured on valid_i && ready_o
//   valid_i, ready_o    input handshake; ready_o high only in IDLE
//   data_div_o          quotient, updated only when the result is packed
//   valid_o, ready_i    output handshake; result held until ready_i
// Fixed latency: accept edge, 8 divide steps, 1 pack edge.
module div_12
  import div_12_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [WORD_W-1:0] data_1_i,
  input  logic [WORD_W-1:0] data_2_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [WORD_W-1:0] data_div_o,
  output logic              valid_o,
  input  logic              ready_i
);

  state_e                    state_q, state_d;
  logic                      sign_q, sign_d;
  logic signed [EXPT_W-1:0]  exp_tmp_q, exp_tmp_d;
  logic                      dvd_zero_q, dvd_zero_d;
  logic                      dvs_zero_q, dvs_zero_d;
  logic [WORD_W-1:0]         data_div_q, data_div_d;

  logic                      core_start;
  logic                      core_done;
  logic [QUOT_W-1:0]         quot;

  logic signed [EXPT_W-1:0]  exp_adj;
  logic [MANT_W-1:0]         mant_pack;
  logic [WORD_W-1:0]         pack_word;

  div_core_7 u_core (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (core_start),
    .dividend_i ({1'b1, data_1_i[MANT_W-1:0]}),
    .divisor_i  ({1'b1, data_2_i[MANT_W-1:0]}),
    .done_o     (core_done),
    .quot_o     (quot)
  );

  // Normalisation and special-case selection for the packed result.
  // The quotient lies in (0.5, 2), so at most one left shift is needed.
  always_comb begin
    if (quot[QUOT_W-1]) begin
      exp_adj   = exp_tmp_q;
      mant_pack = quot[QUOT_W-2:1];
    end else begin
      exp_adj   = exp_tmp_q - 7'sd1;
      mant_pack = quot[MANT_W-1:0];
    end
    if (dvd_zero_q) begin
      pack_word = ZERO_WORD;
    end else if (dvs_zero_q) begin
      pack_word = sat_word(sign_q);
    end else if (exp_adj >= EXP_MAX) begin
      pack_word = sat_word(sign_q);
    end else if (exp_adj <= 7'sd0) begin
      pack_word = ZERO_WORD;
    end else begin
      pack_word = {sign_q, exp_adj[EXP_W-1:0], mant_pack};
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_tmp_d  = exp_tmp_q;
    dvd_zero_d = dvd_zero_q;
    dvs_zero_d = dvs_zero_q;
    data_div_d = data_div_q;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          sign_d     = data_1_i[WORD_W-1] ^ data_2_i[WORD_W-1];
          exp_tmp_d  = $signed({2'b00, data_1_i[MANT_W +: EXP_W]})
                     - $signed({2'b00, data_2_i[MANT_W +: EXP_W]})
                     + BIAS;
          dvd_zero_d = (data_1_i == ZERO_WORD);
          dvs_zero_d = (data_2_i == ZERO_WORD);
          core_start = 1'b1;
          state_d    = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        // Special cases still run all steps to keep latency fixed.
        if (core_done) state_d = ST_PACK;
      end
      ST_PACK: begin
        data_div_d = pack_word;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      exp_tmp_q  <= '0;
      dvd_zero_q <= 1'b0;
      dvs_zero_q <= 1'b0;
      data_div_q <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_tmp_q  <= exp_tmp_d;
      dvd_zero_q <= dvd_zero_d;
      dvs_zero_q <= dvs_zero_d;
      data_div_q <= data_div_d;
    end
  end

  assign ready_o    = (state_q == ST_IDLE);
  assign valid_o    = (state_q == ST_DONE);
  assign data_div_o = data_div_q;

endmodule

// File: tb/tb_div_12.sv
// tb_div_12: directed testbench for div_12.
module tb_div_12;

  logic        clk;
  logic        rst_n;
  logic [11:0] data_1;
  logic [11:0] data_2;
  logic        valid_i;
  logic        ready_o;
  logic [11:0] data_div;
  logic        valid_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;

  div_12 dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .data_1_i   (data_1),
    .data_2_i   (data_2),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_div_o (data_div),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One operation with full handshake; checks exact latency: valid_o is low
  // after 9 edges counting the accept edge and high after the 10th.
  task automatic run_op(input string tag, input logic [11:0] a,
                        input logic [11:0] b, input logic [11:0] expv);
    @(negedge clk);
    check({tag, "_ready_idle"}, {11'd0, ready_o}, 12'd1);
    data_1  = a;
    data_2  = b;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (8) @(negedge clk);
    check({tag, "_valid_early"}, {11'd0, valid_o}, 12'd0);
    @(negedge clk);
    check({tag, "_valid"}, {11'd0, valid_o}, 12'd1);
    check({tag, "_data"}, data_div, expv);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check({tag, "_ready_back"}, {11'd0, ready_o}, 12'd1);
    check({tag, "_valid_drop"}, {11'd0, valid_o}, 12'd0);
  endtask

  initial begin
    logic saw_valid;
    rst_n   = 1'b0;
    data_1  = 12'h000;
    data_2  = 12'h000;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #12;
    check("rst_ready", {11'd0, ready_o}, 12'd1);
    check("rst_valid", {11'd0, valid_o}, 12'd0);
    check("rst_data", data_div, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic quotients, normalisation and truncation
    run_op("one_div_one",   12'h3C0, 12'h3C0, 12'h3C0);
    run_op("three_div_1p5", 12'h420, 12'h3E0, 12'h400);
    run_op("one_div_1p5",   12'h3C0, 12'h3E0, 12'h395);
    // Sign handling
    run_op("neg_dividend",  12'hBC0, 12'h3C0, 12'hBC0);
    run_op("neg_divisor",   12'h3C0, 12'hBC0, 12'hBC0);
    // Zero operands and priority
    run_op("div_by_zero",   12'h3C0, 12'h000, 12'h7FF);
    run_op("zero_dividend", 12'h000, 12'h3C0, 12'h000);
    run_op("zero_by_zero",  12'h000, 12'h000, 12'h000);
    // Exponent range boundaries
    run_op("overflow",      12'h780, 12'h040, 12'h7FF);
    run_op("overflow_neg",  12'hF80, 12'h040, 12'hFFF);
    run_op("underflow",     12'h040, 12'h780, 12'h000);
    run_op("exp_eq_31",     12'h7C0, 12'h3C0, 12'h7FF);
    run_op("exp_31_norm30", 12'h7C0, 12'h3E0, 12'h795);
    run_op("exp_to_0",      12'h040, 12'h3E0, 12'h000);

    // Back-pressure in DONE plus valid_i pulses while busy
    @(negedge clk);
    data_1  = 12'h420;
    data_2  = 12'h3E0;
    valid_i = 1'b1;
    @(negedge clk);
    data_1  = 12'h780;
    data_2  = 12'h040;
    repeat (3) @(negedge clk);
    valid_i = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      data_1  = 12'h3C0;
      data_2  = 12'h000;
      valid_i = 1'b1;
      @(negedge clk);
      check("bp_valid", {11'd0, valid_o}, 12'd1);
      check("bp_data", data_div, 12'h400);
      check("bp_ready", {11'd0, ready_o}, 12'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("bp_ready_back", {11'd0, ready_o}, 12'd1);
    check("bp_idle_hold", data_div, 12'h400);
    @(negedge clk);
    check("bp_idle_hold2", data_div, 12'h400);
    check("bp_no_accept", {11'd0, ready_o}, 12'd1);

    // Asynchronous reset in the middle of DIVIDE
    data_1  = 12'h3C0;
    data_2  = 12'h3E0;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {11'd0, valid_o}, 12'd0);
    check("arst_data", data_div, 12'h000);
    check("arst_ready", {11'd0, ready_o}, 12'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_o) saw_valid = 1'b1;
    end
    check("arst_no_result", {11'd0, saw_valid}, 12'd0);
    run_op("after_reset", 12'h3C0, 12'h3E0, 12'h395);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
